// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: request inputs, memory read data and PC/status outputs.
// slave = fetch unit, master = control logic and instruction memory.
interface fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        halt_req;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus1;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [1:0]  state;
    logic        fault;
    logic [31:0] retired_count;

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
        input  halt_req, instr_in,
        output pc_out, pc_plus1, instr_out, instr_valid, state, fault,
        output retired_count
    );

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
        output halt_req, instr_in,
        input  pc_out, pc_plus1, instr_out, instr_valid, state, fault,
        input  retired_count
    );
endinterface

// File: rtl/fetch_unit.sv
// PC register and fetch control: next-PC selection, range trap,
// sticky HALT/FAULT states and a saturating retired-instruction counter.
module fetch_unit #(
    parameter int          IMEM_DEPTH = 18,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] LP_DEPTH = 32'(IMEM_DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_count;
    logic [31:0] w_pc_inc;
    logic [31:0] w_cand;
    logic        w_oob;
    logic        w_valid;

    // Candidate target and its range check; sign bit set means negative.
    always_comb begin
        w_pc_inc = r_pc + 32'd1;
        w_cand   = w_pc_inc;
        if (bus.jump) begin
            w_cand = {6'b0, bus.jump_target};
        end else if (bus.branch_taken) begin
            w_cand = w_pc_inc + bus.branch_offset;
        end
        w_oob   = w_cand[31] || (w_cand >= LP_DEPTH);
        w_valid = (r_state == S_RUN) && !bus.stall && !bus.halt_req;
    end

    // Next-state and next-PC decision; PC holds unless a legal move happens.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_RUN: begin
                if (bus.halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (!bus.stall) begin
                    if (w_oob) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_pc_nxt = w_cand;
                    end
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_FAULT;
        endcase
    end

    // State, PC and retired counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_valid && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.pc_plus1      = w_pc_inc;
    assign bus.instr_out     = bus.instr_in;
    assign bus.instr_valid   = w_valid;
    assign bus.state         = r_state;
    assign bus.fault         = (r_state == S_FAULT);
    assign bus.retired_count = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written
// sequences for free-run fault, stall, halt and reset behaviour.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_unit_if bus ();

    fetch_unit #(.IMEM_DEPTH(18), .RESET_PC(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: word n holds A500_0000 | n.
    assign bus.instr_in = 32'hA500_0000 | bus.pc_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic        halt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [1:0]  e_state;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_target   = 26'd0;
        bus.halt_req      = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run_to(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic vec_t mk(input logic s, input logic b,
                                input logic [31:0] o, input logic j,
                                input logic [25:0] t, input logic h,
                                input logic [31:0] p, input logic v,
                                input logic [1:0] st, input logic [31:0] c);
        vec_t r;
        r.stall = s; r.br = b; r.off = o; r.jmp = j; r.tgt = t;
        r.halt = h; r.e_pc = p; r.e_valid = v; r.e_state = st;
        r.e_cnt = c;
        return r;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clr();

        vecs[0]  = mk(0, 0, 32'd0,        0, 26'd0,  0, 32'd0,  1, 2'd0, 32'd0);
        vecs[1]  = mk(0, 0, 32'd0,        0, 26'd0,  0, 32'd1,  1, 2'd0, 32'd1);
        vecs[2]  = mk(0, 0, 32'd0,        0, 26'd0,  0, 32'd2,  1, 2'd0, 32'd2);
        vecs[3]  = mk(0, 0, 32'd0,        1, 26'd10, 0, 32'd3,  1, 2'd0, 32'd3);
        vecs[4]  = mk(0, 0, 32'd0,        0, 26'd0,  0, 32'd10, 1, 2'd0, 32'd4);
        vecs[5]  = mk(0, 1, -32'sd5,      0, 26'd0,  0, 32'd11, 1, 2'd0, 32'd5);
        vecs[6]  = mk(1, 0, 32'd0,        1, 26'd15, 0, 32'd7,  0, 2'd0, 32'd6);
        vecs[7]  = mk(1, 0, 32'd0,        1, 26'd15, 0, 32'd7,  0, 2'd0, 32'd6);
        vecs[8]  = mk(0, 0, 32'd0,        1, 26'd15, 0, 32'd7,  1, 2'd0, 32'd6);
        vecs[9]  = mk(0, 1, 32'd2,        1, 26'd12, 0, 32'd15, 1, 2'd0, 32'd7);
        vecs[10] = mk(0, 1, -32'sd20,     0, 26'd0,  0, 32'd12, 1, 2'd0, 32'd8);
        vecs[11] = mk(0, 0, 32'd0,        0, 26'd0,  0, 32'd12, 0, 2'd2, 32'd9);
        vecs[12] = mk(0, 0, 32'd0,        1, 26'd3,  0, 32'd12, 0, 2'd2, 32'd9);

        step();
        reset = 1'b0;
        chk("reset_pc", bus.pc_out, 32'd0);
        chk("reset_state", {30'd0, bus.state}, 32'd0);
        chk("reset_fault", {31'd0, bus.fault}, 32'd0);
        chk("reset_cnt", bus.retired_count, 32'd0);
        chk("reset_pc1", bus.pc_plus1, 32'd1);

        // Table-driven sequence.
        for (int i = 0; i < 13; i++) begin
            bus.stall         = vecs[i].stall;
            bus.branch_taken  = vecs[i].br;
            bus.branch_offset = vecs[i].off;
            bus.jump          = vecs[i].jmp;
            bus.jump_target   = vecs[i].tgt;
            bus.halt_req      = vecs[i].halt;
            #1;
            chk($sformatf("v%0d_pc", i), bus.pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d_pc1", i), bus.pc_plus1, vecs[i].e_pc + 1);
            chk($sformatf("v%0d_instr", i), bus.instr_out,
                32'hA500_0000 | vecs[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'd0, bus.instr_valid},
                {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_state", i), {30'd0, bus.state},
                {30'd0, vecs[i].e_state});
            chk($sformatf("v%0d_fault", i), {31'd0, bus.fault},
                {31'd0, vecs[i].e_state == 2'd2});
            chk($sformatf("v%0d_cnt", i), bus.retired_count, vecs[i].e_cnt);
            step();
        end

        // Free run from reset until the sequential step past word 17.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("run_pc%0d", i), bus.pc_out, 32'(i));
            step();
        end
        chk("run_fault", {31'd0, bus.fault}, 32'd1);
        chk("run_state", {30'd0, bus.state}, 32'd2);
        chk("run_pc_hold", bus.pc_out, 32'd17);
        chk("run_cnt", bus.retired_count, 32'd18);
        chk("run_valid", {31'd0, bus.instr_valid}, 32'd0);

        // Jump at pc 3 to 10.
        do_reset();
        run_to(3);
        bus.jump = 1'b1; bus.jump_target = 26'd10;
        step();
        clr();
        chk("jmp_pc", bus.pc_out, 32'd10);
        chk("jmp_instr", bus.instr_out, 32'hA500_000A);

        // Branch -5 at pc 8 lands on 4.
        do_reset();
        run_to(8);
        bus.branch_taken = 1'b1; bus.branch_offset = -32'sd5;
        step();
        clr();
        chk("br_pc", bus.pc_out, 32'd4);
        chk("br_state", {30'd0, bus.state}, 32'd0);

        // Branch -4 at pc 2 gives -1: fault, pc held.
        do_reset();
        run_to(2);
        bus.branch_taken = 1'b1; bus.branch_offset = -32'sd4;
        step();
        clr();
        chk("brneg_pc", bus.pc_out, 32'd2);
        chk("brneg_fault", {31'd0, bus.fault}, 32'd1);
        chk("brneg_cnt", bus.retired_count, 32'd3);

        // Stall three cycles at pc 5 with jump held, then jump lands.
        do_reset();
        run_to(5);
        bus.jump = 1'b1; bus.jump_target = 26'd9; bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stl_valid%0d", i), {31'd0, bus.instr_valid}, 32'd0);
            step();
            chk($sformatf("stl_pc%0d", i), bus.pc_out, 32'd5);
            chk($sformatf("stl_cnt%0d", i), bus.retired_count, 32'd5);
        end
        bus.stall = 1'b0;
        step();
        clr();
        chk("stl_jmp_pc", bus.pc_out, 32'd9);
        chk("stl_jmp_cnt", bus.retired_count, 32'd6);

        // Halt at pc 6; jumps ignored; reset recovers.
        do_reset();
        run_to(6);
        bus.halt_req = 1'b1;
        #1;
        chk("halt_req_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        clr();
        chk("halt_state", {30'd0, bus.state}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.jump = 1'b1; bus.jump_target = 26'd2;
            #1;
            chk($sformatf("halt_valid%0d", i), {31'd0, bus.instr_valid}, 32'd0);
            step();
            chk($sformatf("halt_pc%0d", i), bus.pc_out, 32'd6);
        end
        chk("halt_cnt", bus.retired_count, 32'd6);
        bus.jump = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        chk("rst_pc", bus.pc_out, 32'd0);
        chk("rst_state", {30'd0, bus.state}, 32'd0);
        chk("rst_cnt", bus.retired_count, 32'd0);

        // Jump and branch together at pc 1: jump wins.
        step();
        bus.jump = 1'b1; bus.jump_target = 26'd12;
        bus.branch_taken = 1'b1; bus.branch_offset = 32'd2;
        step();
        clr();
        chk("jb_pc", bus.pc_out, 32'd12);

        // Reset out of FAULT.
        bus.jump = 1'b1; bus.jump_target = 26'd18;
        step();
        clr();
        chk("oob_jmp_fault", {31'd0, bus.fault}, 32'd1);
        chk("oob_jmp_pc", bus.pc_out, 32'd12);
        do_reset();
        chk("fault_rst_state", {30'd0, bus.state}, 32'd0);
        chk("fault_rst_pc", bus.pc_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
